// File: rtl/axi_isolate_ctrl.sv
// axi_isolate_ctrl: gates AXI handshakes upstream of axi_cdc, counts in-flight bursts and quiesces the crossing on request.
module axi_isolate_ctrl #(
    parameter int unsigned MaxTxns  = 8,
    parameter int unsigned CntWidth = $clog2(MaxTxns + 1)
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic isolate_i,
    output logic isolated_o,
    input  logic slv_aw_valid_i,
    output logic slv_aw_ready_o,
    output logic mst_aw_valid_o,
    input  logic mst_aw_ready_i,
    input  logic slv_w_valid_i,
    input  logic slv_w_last_i,
    output logic slv_w_ready_o,
    output logic mst_w_valid_o,
    input  logic mst_w_ready_i,
    input  logic mst_b_valid_i,
    input  logic slv_b_ready_i,
    input  logic slv_ar_valid_i,
    output logic slv_ar_ready_o,
    output logic mst_ar_valid_o,
    input  logic mst_ar_ready_i,
    input  logic mst_r_valid_i,
    input  logic mst_r_last_i,
    input  logic slv_r_ready_i
);
    typedef enum logic [1:0] {NORMAL, DRAIN, ISOLATED} state_e;
    localparam logic [CntWidth-1:0] Max = CntWidth'(MaxTxns);
    state_e state, state_next;
    logic [CntWidth-1:0] wr_cnt, rd_cnt, w_cnt;
    logic aw_hold, ar_hold, w_hold, en_aw, en_ar, en_w, idle;
    logic aw_hs, ar_hs, w_last_hs, b_hs, r_last_hs;

    function automatic logic [CntWidth-1:0] step(input logic [CntWidth-1:0] c, input logic inc, input logic dec);
        return (inc && !dec) ? c + 1'b1 : (dec && !inc && c != '0) ? c - 1'b1 : c;
    endfunction

    assign mst_aw_valid_o = slv_aw_valid_i & en_aw;
    assign slv_aw_ready_o = mst_aw_ready_i & en_aw;
    assign mst_ar_valid_o = slv_ar_valid_i & en_ar;
    assign slv_ar_ready_o = mst_ar_ready_i & en_ar;
    assign mst_w_valid_o  = slv_w_valid_i & en_w;
    assign slv_w_ready_o  = mst_w_ready_i & en_w;
    assign aw_hs     = mst_aw_valid_o & mst_aw_ready_i;
    assign ar_hs     = mst_ar_valid_o & mst_ar_ready_i;
    assign w_last_hs = mst_w_valid_o & mst_w_ready_i & slv_w_last_i;
    assign b_hs      = mst_b_valid_i & slv_b_ready_i;
    assign r_last_hs = mst_r_valid_i & slv_r_ready_i & mst_r_last_i;
    assign idle = wr_cnt == '0 && rd_cnt == '0 && w_cnt == '0 && !aw_hold && !ar_hold;

    always_ff @(posedge clk_i) begin
        if (rst_i) state <= NORMAL;
        else       state <= state_next;
    end

    always_comb begin
        state_next = !isolate_i ? NORMAL :
                     (state == NORMAL) ? DRAIN :
                     (state == DRAIN && idle) ? ISOLATED : state;
    end

    // Holds keep an already-presented valid alive across state or counter changes.
    always_comb begin
        en_aw = (state == NORMAL && wr_cnt < Max) || aw_hold;
        en_ar = (state == NORMAL && rd_cnt < Max) || ar_hold;
        en_w  = state != ISOLATED || w_hold;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_cnt     <= '0;
            rd_cnt     <= '0;
            w_cnt      <= '0;
            aw_hold    <= 1'b0;
            ar_hold    <= 1'b0;
            w_hold     <= 1'b0;
            isolated_o <= 1'b0;
        end else begin
            wr_cnt     <= step(wr_cnt, aw_hs, b_hs);
            rd_cnt     <= step(rd_cnt, ar_hs, r_last_hs);
            w_cnt      <= step(w_cnt, aw_hs, w_last_hs);
            aw_hold    <= mst_aw_valid_o & ~mst_aw_ready_i;
            ar_hold    <= mst_ar_valid_o & ~mst_ar_ready_i;
            w_hold     <= mst_w_valid_o & ~mst_w_ready_i;
            isolated_o <= state_next == ISOLATED;
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            assert (!(b_hs && !aw_hs && wr_cnt == '0));
            assert (!(r_last_hs && !ar_hs && rd_cnt == '0));
            assert (!(w_last_hs && !aw_hs && w_cnt == '0));
        end
    end
`endif
endmodule

// File: tb/tb_axi_isolate_ctrl.sv
// tb_axi_isolate_ctrl: directed per-cycle vectors checked by a queue-based scoreboard monitor.
module tb_axi_isolate_ctrl;
    typedef struct {
        string      n;
        logic [6:0] out;
        int         wr, rd, w;
    } exp_t;

    logic clk = 1'b0;
    logic rst_i = 1'b1, isolate_i = 1'b0;
    logic aw_v = 1'b0, aw_r = 1'b0, ar_v = 1'b0, ar_r = 1'b0;
    logic w_v = 1'b0, w_l = 1'b0, w_r = 1'b0, b_v = 1'b0, r_v = 1'b0, r_l = 1'b0;
    logic b_rdy = 1'b1, r_rdy = 1'b1;
    logic isolated_o, slv_aw_ready_o, mst_aw_valid_o, slv_w_ready_o, mst_w_valid_o;
    logic slv_ar_ready_o, mst_ar_valid_o;
    exp_t exp_q[$];
    int vectors = 0, miscompares = 0;

    always #5 clk = ~clk;

    axi_isolate_ctrl #(.MaxTxns(8)) dut (
        .clk_i(clk), .rst_i(rst_i), .isolate_i(isolate_i), .isolated_o(isolated_o),
        .slv_aw_valid_i(aw_v), .slv_aw_ready_o(slv_aw_ready_o),
        .mst_aw_valid_o(mst_aw_valid_o), .mst_aw_ready_i(aw_r),
        .slv_w_valid_i(w_v), .slv_w_last_i(w_l), .slv_w_ready_o(slv_w_ready_o),
        .mst_w_valid_o(mst_w_valid_o), .mst_w_ready_i(w_r),
        .mst_b_valid_i(b_v), .slv_b_ready_i(b_rdy),
        .slv_ar_valid_i(ar_v), .slv_ar_ready_o(slv_ar_ready_o),
        .mst_ar_valid_o(mst_ar_valid_o), .mst_ar_ready_i(ar_r),
        .mst_r_valid_i(r_v), .mst_r_last_i(r_l), .slv_r_ready_i(r_rdy)
    );

    // in  = {rst, iso, aw_v, aw_r, ar_v, ar_r, w_v, w_l, w_r, b_v, r_v, r_l}
    // out = {isolated, mst_aw_valid, slv_aw_ready, mst_ar_valid, slv_ar_ready, mst_w_valid, slv_w_ready}
    task automatic v(input string n, input logic [11:0] in, input logic [6:0] out, input int wr, input int rd, input int w);
        exp_t e;
        @(posedge clk);
        #1;
        {rst_i, isolate_i, aw_v, aw_r, ar_v, ar_r, w_v, w_l, w_r, b_v, r_v, r_l} = in;
        e.n = n; e.out = out; e.wr = wr; e.rd = rd; e.w = w;
        exp_q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            logic [6:0] act;
            e = exp_q.pop_front();
            act = {isolated_o, mst_aw_valid_o, slv_aw_ready_o, mst_ar_valid_o, slv_ar_ready_o, mst_w_valid_o, slv_w_ready_o};
            vectors++;
            if (act !== e.out || int'(dut.wr_cnt) != e.wr || int'(dut.rd_cnt) != e.rd || int'(dut.w_cnt) != e.w) begin
                miscompares++;
                $display("FAIL %s: out=%b cnt=%0d/%0d/%0d, required out=%b cnt=%0d/%0d/%0d",
                         e.n, act, dut.wr_cnt, dut.rd_cnt, dut.w_cnt, e.out, e.wr, e.rd, e.w);
            end
        end
    end

    initial begin
        repeat (2) @(posedge clk);
        v("reset_idle",   12'b00_01_01_001_0_00, 7'b0_01_01_01, 0, 0, 0);
        v("iso_req",      12'b01_01_01_001_0_00, 7'b0_01_01_01, 0, 0, 0);
        v("iso_drain",    12'b01_01_01_001_0_00, 7'b0_00_00_01, 0, 0, 0);
        v("iso_set",      12'b01_01_01_001_0_00, 7'b1_00_00_00, 0, 0, 0);
        v("iso_hold",     12'b01_01_01_001_0_00, 7'b1_00_00_00, 0, 0, 0);
        v("iso_release",  12'b00_01_01_001_0_00, 7'b1_00_00_00, 0, 0, 0);
        v("iso_normal",   12'b00_01_01_001_0_00, 7'b0_01_01_01, 0, 0, 0);
        for (int k = 0; k < 3; k++)
            v("wr_issue",  12'b00_11_01_111_0_00, 7'b0_11_01_11, k, 0, 0);
        v("wr_iso_req",   12'b01_01_01_001_0_00, 7'b0_01_01_01, 3, 0, 0);
        v("aw_blocked",   12'b01_11_01_001_0_00, 7'b0_00_00_01, 3, 0, 0);
        for (int k = 3; k > 0; k--)
            v("b_release", 12'b01_11_01_001_1_00, 7'b0_00_00_01, k, 0, 0);
        v("wr_drained",   12'b01_11_01_001_0_00, 7'b0_00_00_01, 0, 0, 0);
        v("wr_isolated",  12'b01_11_01_001_0_00, 7'b1_00_00_00, 0, 0, 0);
        v("wr_release",   12'b00_01_01_001_0_00, 7'b1_00_00_00, 0, 0, 0);
        v("wr_normal",    12'b00_01_01_001_0_00, 7'b0_01_01_01, 0, 0, 0);
        v("aw_only_1",    12'b00_11_01_001_0_00, 7'b0_11_01_01, 0, 0, 0);
        v("aw_only_2",    12'b00_11_01_001_0_00, 7'b0_11_01_01, 1, 0, 1);
        v("aw_and_b",     12'b00_11_01_001_1_00, 7'b0_11_01_01, 2, 0, 2);
        v("b_wlast_1",    12'b00_01_01_111_1_00, 7'b0_01_01_11, 2, 0, 3);
        v("b_wlast_2",    12'b00_01_01_111_1_00, 7'b0_01_01_11, 1, 0, 2);
        v("wlast_3",      12'b00_01_01_111_0_00, 7'b0_01_01_11, 0, 0, 1);
        v("wr_clean",     12'b00_01_01_001_0_00, 7'b0_01_01_01, 0, 0, 0);
        v("aw_stall_iso", 12'b01_10_01_001_0_00, 7'b0_10_01_01, 0, 0, 0);
        v("aw_held",      12'b01_10_01_001_0_00, 7'b0_10_00_01, 0, 0, 0);
        v("aw_held_hs",   12'b01_11_01_001_0_00, 7'b0_11_00_01, 0, 0, 0);
        v("held_wlast",   12'b01_01_01_111_0_00, 7'b0_00_00_11, 1, 0, 1);
        v("held_b",       12'b01_01_01_001_1_00, 7'b0_00_00_01, 1, 0, 0);
        v("held_drained", 12'b01_01_01_001_0_00, 7'b0_00_00_01, 0, 0, 0);
        v("held_isol",    12'b01_01_01_001_0_00, 7'b1_00_00_00, 0, 0, 0);
        v("held_release", 12'b00_01_01_001_0_00, 7'b1_00_00_00, 0, 0, 0);
        v("held_normal",  12'b00_01_01_001_0_00, 7'b0_01_01_01, 0, 0, 0);
        for (int k = 0; k < 8; k++)
            v("ar_issue",  12'b00_01_11_001_0_00, 7'b0_01_11_01, 0, k, 0);
        v("ar_cap",       12'b00_01_11_001_0_00, 7'b0_01_00_01, 0, 8, 0);
        v("ar_cap_rlast", 12'b00_01_11_001_0_11, 7'b0_01_00_01, 0, 8, 0);
        v("ar_reenabled", 12'b00_01_11_001_0_00, 7'b0_01_11_01, 0, 7, 0);
        v("r_no_last",    12'b00_01_01_001_0_10, 7'b0_01_00_01, 0, 8, 0);
        v("r_last_8",     12'b00_01_01_001_0_11, 7'b0_01_00_01, 0, 8, 0);
        for (int k = 7; k > 4; k--)
            v("r_last",    12'b00_01_01_001_0_11, 7'b0_01_01_01, 0, k, 0);
        v("rd_iso_req",   12'b01_01_01_001_0_00, 7'b0_01_01_01, 0, 4, 0);
        v("rd_drain",     12'b01_01_01_001_0_00, 7'b0_00_00_01, 0, 4, 0);
        v("rst_in_drain", 12'b11_01_01_001_0_00, 7'b0_00_00_01, 0, 4, 0);
        v("post_reset",   12'b00_01_01_001_0_00, 7'b0_01_01_01, 0, 0, 0);
        @(posedge clk);
        for (int i = 0; i < 100 && exp_q.size() > 0; i++) @(posedge clk);
        if (exp_q.size() > 0) begin
            miscompares++;
            $display("FAIL drain_timeout: %0d vectors unchecked, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
